z3_master_cycle: RTL and testbench
==================================

# z3_master_cycle

Zorro III bus-master cycle sequencer for the A4091 DMA path. Once the DMA arbiter has won the bus (`mybus` high), it turns each SCSI-chip master access into one complete Zorro III cycle. The sequence is: address setup, `FCS_n`, byte-lane data strobes and `DOE`, wait for `DTACK_n`, acknowledge the SCSI chip, then release. It decodes byte lanes from size/address, bounds every cycle with a timeout, and never starts a cycle without the grant.

## Interface
Parameters:
- `ADDR_SETUP`, default 1: clk cycles from cycle start to `FCS_n` assertion (1..7).
- `DATA_SETUP`, default 1: clk cycles from `FCS_n` to `DS_n`/`DOE` assertion (1..7).
- `TIMEOUT`, default 255: clk cycles in WAIT before abort (1..1023, counter 10 bits).

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `IORST_n` in 1: asynchronous active-low reset.
- `mybus` in 1: Zorro III bus owned by the card (from the DMA arbiter).
- `SAS_n` in 1: SCSI-chip master address strobe, synchronous to `clk`.
- `SRW` in 1: SCSI-chip direction; 1 = read.
- `SSIZ` in 2: transfer size; 00 = long, 01 = byte, 10 = word, 11 = 3-byte.
- `SA` in 2: low address bits A1:A0.
- `DTACK_n` in 1: Zorro III data acknowledge; asynchronous, synchronised internally.
- `FCS_n` out 1: Zorro III full cycle strobe.
- `DS_n` out 4: data strobes `DS_n[3]` = D31:24 through `DS_n[0]` = D7:0.
- `DOE` out 1: data output enable / buffer enable.
- `READ` out 1: Zorro III read line.
- `SLACK_n` out 1: cycle-complete acknowledge to the SCSI chip.
- `SBERR_n` out 1: bus-error termination to the SCSI chip.
- `busy` out 1: a cycle is in progress (state ≠ IDLE).

## Operation
- States: IDLE, ADDR, STROBE, DATA, ACK, ERR, RELEASE.
- IDLE:
  - Start when `SAS_n`=0 and `mybus`=1 at an edge; latch `SRW`, `SSIZ`, `SA`; go to ADDR.
  - If `mybus`=0, `SAS_n` low is ignored; wait.
- ADDR: hold `ADDR_SETUP` cycles, then go to STROBE (`FCS_n`=0).
- STROBE: hold `DATA_SETUP` cycles, then go to DATA (`DS_n` = lane mask, `DOE`=1), clearing the timeout counter.
- DATA/WAIT:
  - Synchronised `DTACK_n`=0 → ACK.
  - Counter reaches `TIMEOUT` → ERR.
  - DTACK wins if both occur in the same cycle.
- ACK:
  - `SLACK_n`=0 for exactly one cycle.
  - `FCS_n`, `DS_n` and `DOE` negate on entry.
  - Then go to RELEASE.
- ERR: `SBERR_n`=0 for exactly one cycle, strobes negate on entry, then go to RELEASE. `SLACK_n` is never asserted on an aborted cycle.
- RELEASE: wait until `SAS_n`=1 and synchronised `DTACK_n`=1, then go to IDLE.
- `mybus` falling after start does not abort; the cycle completes normally.
- `READ` is driven from latched `SRW` from ADDR through RELEASE; it is 1 in IDLE.
- Lane decode (active-low mask on `DS_n[3:0]`, `SA` big-endian):
  - Byte: only lane 3−`SA` asserted.
  - Word: `SA[1]`=0 → lanes 3,2; `SA[1]`=1 → lanes 1,0 (`SA[0]` ignored).
  - 3-byte: `SA`=0 → lanes 3..1; otherwise lanes 2..0.
  - Long: all four lanes (`SA` ignored).
- Reset (async, any state): state IDLE, counter 0, sync flops 1.
  - Output reset values: `FCS_n`=1, `DS_n`=4'hF, `DOE`=0, `READ`=1, `SLACK_n`=1, `SBERR_n`=1, `busy`=0.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Start sampled at edge E0: `busy`=1 after E0, `FCS_n`=0 after E0+`ADDR_SETUP`, and `DS_n`/`DOE` active after E0+`ADDR_SETUP`+`DATA_SETUP`. With defaults these are E0+1 and E0+2.
- `DTACK_n` uses a 2-flop synchroniser. Low first sampled at edge T → `SLACK_n`=0 and strobes negated after edge T+2, `SLACK_n` back to 1 after T+3.
- Timeout: ERR is entered on the edge where the counter, cleared on DATA entry, equals `TIMEOUT`. `SBERR_n` low is `TIMEOUT`+1 cycles after the `DS_n` assert.
- Back-to-back cycles: the earliest restart is the edge after RELEASE exits. `FCS_n` stays high for at least 2 cycles between cycles.
- Reset mid-cycle: outputs take reset values immediately (asynchronously). There is no `SLACK_n`/`SBERR_n` pulse on reset.

## Test plan
- Long read, `SA`=0, `mybus`=1, `DTACK_n` low 4 cycles after `DS_n` → `READ`=1, `DS_n`=0000, `FCS_n` low for 7 cycles, one `SLACK_n` pulse, `busy` drops after `SAS_n` rises.
- Byte write at `SA`=2 → `DS_n`=1101, `READ`=0, `DOE`=1 during DATA. Word at `SA`=3 → `DS_n`=1100. 3-byte at `SA`=1 → `DS_n`=1000.
- `SAS_n` low with `mybus`=0 for 20 cycles → `FCS_n` stays 1. Raise `mybus` → `FCS_n`=0 two edges later.
- `TIMEOUT`=8, no `DTACK_n` → `SBERR_n` low for 1 cycle, 9 cycles after `DS_n` assert; `SLACK_n` stays 1; return to IDLE once `SAS_n`=1.
- Drop `mybus` during WAIT, then `DTACK_n` → cycle completes with `SLACK_n`; no new cycle starts while `mybus`=0.
- Assert `IORST_n`=0 mid-DATA → all outputs take reset values within the same cycle; after release, a fresh long read completes normally.

Source files
------------

// File: rtl/z3_master_cycle.sv
// z3_master_cycle: Zorro III bus-master cycle sequencer for the A4091 DMA path.
// Ports: clk, IORST_n (async active-low reset); mybus (bus granted to card);
//   SAS_n/SRW/SSIZ/SA (SCSI-chip master request, size, low address);
//   DTACK_n (async Zorro III acknowledge); FCS_n/DS_n/DOE/READ (Zorro III strobes);
//   SLACK_n/SBERR_n (completion / bus error back to the SCSI chip); busy (cycle in progress).
module z3_master_cycle #(
  parameter int ADDR_SETUP = 1,
  parameter int DATA_SETUP = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       IORST_n,
  input  logic       mybus,
  input  logic       SAS_n,
  input  logic       SRW,
  input  logic [1:0] SSIZ,
  input  logic [1:0] SA,
  input  logic       DTACK_n,
  output logic       FCS_n,
  output logic [3:0] DS_n,
  output logic       DOE,
  output logic       READ,
  output logic       SLACK_n,
  output logic       SBERR_n,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ADDR, STROBE, DATA, ACK, ERR, RELEASE} state_t;
  localparam logic [9:0] AS_LAST = 10'(ADDR_SETUP - 1);
  localparam logic [9:0] DS_LAST = 10'(DATA_SETUP - 1);
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT);
  state_t     state;
  logic [9:0] cnt;
  logic       dt1, dt2;
  logic [1:0] siz, sa;
  logic [3:0] lanes;
  // big-endian lane mask, active low: lane 3 carries D31:24 at SA=0
  always_comb lanes = siz == 2'b01 ? ~(4'b1000 >> sa) :
                      siz == 2'b10 ? (sa[1] ? 4'b1100 : 4'b0011) :
                      siz == 2'b11 ? (sa == 2'b00 ? 4'b0001 : 4'b1000) : 4'b0000;
  always_ff @(posedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      state   <= IDLE;
      cnt     <= '0;
      dt1     <= 1'b1;
      dt2     <= 1'b1;
      siz     <= 2'b00;
      sa      <= 2'b00;
      FCS_n   <= 1'b1;
      DS_n    <= 4'hF;
      DOE     <= 1'b0;
      READ    <= 1'b1;
      SLACK_n <= 1'b1;
      SBERR_n <= 1'b1;
      busy    <= 1'b0;
    end else begin
      dt1 <= DTACK_n;
      dt2 <= dt1;
      case (state)
        IDLE: if (!SAS_n && mybus) begin
          state <= ADDR;
          busy  <= 1'b1;
          READ  <= SRW;
          siz   <= SSIZ;
          sa    <= SA;
          cnt   <= '0;
        end
        ADDR: if (cnt == AS_LAST) begin
          state <= STROBE;
          FCS_n <= 1'b0;
          cnt   <= '0;
        end else cnt <= cnt + 10'd1;
        STROBE: if (cnt == DS_LAST) begin
          state <= DATA;
          DS_n  <= lanes;
          DOE   <= 1'b1;
          cnt   <= '0;
        end else cnt <= cnt + 10'd1;
        // acknowledge is tested first so it wins over a simultaneous timeout
        DATA: if (!dt2) begin
          state   <= ACK;
          SLACK_n <= 1'b0;
          FCS_n   <= 1'b1;
          DS_n    <= 4'hF;
          DOE     <= 1'b0;
        end else if (cnt == TO_LAST) begin
          state   <= ERR;
          SBERR_n <= 1'b0;
          FCS_n   <= 1'b1;
          DS_n    <= 4'hF;
          DOE     <= 1'b0;
        end else cnt <= cnt + 10'd1;
        ACK: begin
          state   <= RELEASE;
          SLACK_n <= 1'b1;
        end
        ERR: begin
          state   <= RELEASE;
          SBERR_n <= 1'b1;
        end
        // hold the bus until the chip drops its strobe and the target drops DTACK
        RELEASE: if (SAS_n && dt2) begin
          state <= IDLE;
          busy  <= 1'b0;
          READ  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_z3_master_cycle.sv
// tb_z3_master_cycle: scoreboard bench for the Zorro III master cycle sequencer.
module tb_z3_master_cycle;
  localparam int TO = 8;
  typedef struct {
    logic [1:0] term;
    logic [3:0] ds;
    logic       rd;
    int         lat;
    int         fcs;
  } exp_t;
  logic       clk = 1'b0;
  logic       IORST_n = 1'b1;
  logic       mybus = 1'b1;
  logic       SAS_n = 1'b1;
  logic       SRW = 1'b1;
  logic [1:0] SSIZ = 2'b00;
  logic [1:0] SA = 2'b00;
  logic       DTACK_n = 1'b1;
  logic       FCS_n, DOE, READ, SLACK_n, SBERR_n, busy;
  logic [3:0] DS_n;
  exp_t       q[$];
  int         total = 0, fails = 0;
  int         cyc = 0, ds_cyc = 0, fcs_len = 0, hi_len = 100;
  logic [3:0] prev_ds = 4'hF, cap_ds = 4'hF;
  logic       prev_fcs = 1'b1, cap_rd = 1'b0, cap_doe = 1'b0;
  z3_master_cycle #(.TIMEOUT(TO)) dut (
    .clk(clk), .IORST_n(IORST_n), .mybus(mybus), .SAS_n(SAS_n), .SRW(SRW),
    .SSIZ(SSIZ), .SA(SA), .DTACK_n(DTACK_n), .FCS_n(FCS_n), .DS_n(DS_n),
    .DOE(DOE), .READ(READ), .SLACK_n(SLACK_n), .SBERR_n(SBERR_n), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] lane_model(input logic [1:0] siz, input logic [1:0] sa);
    logic [3:0] m;
    int top, n;
    m = 4'hF;
    top = (siz == 2'b11 && sa != 2'b00) ? 2 : (siz == 2'b10 && sa[1]) ? 1 :
          (siz == 2'b01) ? 3 - int'(sa) : 3;
    n = siz == 2'b00 ? 4 : siz == 2'b01 ? 1 : siz == 2'b10 ? 2 : 3;
    for (int i = 0; i < n; i++) m[top - i] = 1'b0;
    return m;
  endfunction
  task automatic start_cycle(input logic rd, input logic [1:0] siz, input logic [1:0] sa,
                             input int k, input bit err);
    exp_t e;
    e.term = err ? 2'b10 : 2'b01;
    e.ds   = lane_model(siz, sa);
    e.rd   = rd;
    e.lat  = err ? TO + 1 : k + 3;
    e.fcs  = err ? TO + 2 : k + 4;
    q.push_back(e);
    SRW = rd;
    SSIZ = siz;
    SA = sa;
    SAS_n = 1'b0;
  endtask
  task automatic wait_ds();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (DS_n == 4'hF && n < 40);
    chk("ds_wait", 32'(DS_n != 4'hF), 32'd1);
  endtask
  task automatic finish_cycle(input int k, input bit err, input bit drop);
    int n = 0;
    wait_ds();
    if (drop) mybus = 1'b0;
    if (!err) begin
      repeat (k) @(negedge clk);
      DTACK_n = 1'b0;
    end
    do begin
      @(negedge clk);
      n++;
    end while (SLACK_n && SBERR_n && n < 40);
    chk("term_wait", 32'(!(SLACK_n && SBERR_n)), 32'd1);
    chk("busy_hold", 32'(busy), 32'd1);
    SAS_n = 1'b1;
    DTACK_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 20);
    chk("idle_state", 32'({busy, FCS_n, READ, DS_n}), 32'(7'b0111111));
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (DS_n != 4'hF && prev_ds == 4'hF) begin
        ds_cyc = cyc;
        cap_ds = DS_n;
        cap_rd = READ;
        cap_doe = DOE;
      end
      if (!FCS_n) begin
        if (prev_fcs) begin
          chk("fcs_gap", 32'(hi_len >= 2), 32'd1);
          fcs_len = 0;
        end
        fcs_len++;
      end else hi_len = prev_fcs ? hi_len + 1 : 1;
      if (!SLACK_n || !SBERR_n) begin
        if (q.size() == 0) chk("sb_pending", 32'(q.size()), 32'd1);
        else begin
          e = q.pop_front();
          chk("term", 32'({SLACK_n, SBERR_n}), 32'(e.term));
          chk("lanes", 32'(cap_ds), 32'(e.ds));
          chk("read", 32'(cap_rd), 32'(e.rd));
          chk("read_hold", 32'(READ), 32'(e.rd));
          chk("doe", 32'(cap_doe), 32'd1);
          chk("latency", 32'(cyc - ds_cyc), 32'(e.lat));
          chk("fcs_len", 32'(fcs_len), 32'(e.fcs));
          chk("strobes_off", 32'({FCS_n, DOE, DS_n}), 32'(6'b101111));
        end
      end
      prev_ds = DS_n;
      prev_fcs = FCS_n;
    end
  end
  initial begin
    logic       bad, rd;
    logic [1:0] siz, sa;
    int         k;
    #1 IORST_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({FCS_n, DS_n, DOE, READ, SLACK_n, SBERR_n, busy}), 32'(10'b1111101110));
    IORST_n = 1'b1;
    @(negedge clk);
    start_cycle(1'b1, 2'b00, 2'd0, 3, 1'b0);
    finish_cycle(3, 1'b0, 1'b0);
    start_cycle(1'b0, 2'b01, 2'd2, 1, 1'b0);
    finish_cycle(1, 1'b0, 1'b0);
    start_cycle(1'b0, 2'b10, 2'd3, 0, 1'b0);
    finish_cycle(0, 1'b0, 1'b0);
    start_cycle(1'b1, 2'b11, 2'd1, 2, 1'b0);
    finish_cycle(2, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rd = 1'($urandom_range(1));
      siz = 2'($urandom_range(3));
      sa = 2'($urandom_range(3));
      k = int'($urandom_range(4));
      start_cycle(rd, siz, sa, k, 1'b0);
      finish_cycle(k, 1'b0, 1'b0);
    end
    start_cycle(1'b0, 2'b00, 2'd0, 0, 1'b1);
    finish_cycle(0, 1'b1, 1'b0);
    mybus = 1'b0;
    start_cycle(1'b0, 2'b10, 2'd0, 2, 1'b0);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      bad = bad | !FCS_n | busy;
    end
    chk("nobus_idle", 32'(bad), 32'd0);
    mybus = 1'b1;
    @(negedge clk);
    chk("nobus_start", 32'({busy, FCS_n}), 32'(2'b11));
    @(negedge clk);
    chk("nobus_fcs", 32'(FCS_n), 32'd0);
    finish_cycle(2, 1'b0, 1'b0);
    start_cycle(1'b1, 2'b00, 2'd0, 3, 1'b0);
    finish_cycle(3, 1'b0, 1'b1);
    SAS_n = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      bad = bad | busy | !FCS_n;
    end
    chk("nobus_after_drop", 32'(bad), 32'd0);
    SAS_n = 1'b1;
    @(negedge clk);
    mybus = 1'b1;
    start_cycle(1'b1, 2'b00, 2'd0, 3, 1'b0);
    wait_ds();
    #2 IORST_n = 1'b0;
    #1 chk("reset_async", 32'({FCS_n, DS_n, DOE, READ, SLACK_n, SBERR_n, busy}), 32'(10'b1111101110));
    void'(q.pop_front());
    SAS_n = 1'b1;
    repeat (2) @(negedge clk);
    IORST_n = 1'b1;
    @(negedge clk);
    start_cycle(1'b1, 2'b00, 2'd0, 2, 1'b0);
    finish_cycle(2, 1'b0, 1'b0);
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
